// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM state encoding
//   HLT_OPCODE    : opcode nibble that stops fetching
//   NOP_WORD      : bubble word presented when no instruction is valid
//   PC_RESET      : program counter value after reset
//   PC_INC        : sequential PC step (16-bit instructions)
//   sat_inc16     : saturating 16-bit increment used by the optional counters
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP,
    ST_HALTED
  } fetch_state_e;

  localparam logic [3:0]  HLT_OPCODE = 4'b1111;
  localparam logic [15:0] NOP_WORD   = 16'h0000;
  localparam logic [15:0] PC_RESET   = 16'h0000;
  localparam logic [15:0] PC_INC     = 16'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction memory read channel.
//   imem_req   : one-cycle read request pulse (fetch -> memory)
//   imem_addr  : read address, valid with imem_req (fetch -> memory)
//   imem_valid : read data valid, at least one cycle after the request (memory -> fetch)
//   imem_rdata : instruction word, valid with imem_valid (memory -> fetch)
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with one outstanding memory read.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset (synchronously deasserted upstream)
//   stall        : 1 = presented instruction not consumed this cycle
//   br_taken     : redirect pulse, highest priority in every state
//   br_target    : redirect PC (bit 0 ignored)
//   imem         : instruction memory channel (fetch_unit_if.master)
//   IF_Instr     : presented instruction, NOP_WORD when instr_valid = 0
//   PC_out       : PC of presented instruction + 2
//   instr_valid  : IF_Instr holds a real fetched instruction
//   fetch_halted : fetch stopped on an HLT instruction
// Optional feature (macro FETCH_PERF_CNT_EN): adds saturating counters
//   wait_cycles  (cycles spent in WAIT or DROP) and
//   stall_cycles (cycles in HOLD with stall = 1).
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  fetch_unit_if.master imem,
  output logic [15:0] IF_Instr,
  output logic [15:0] PC_out,
  output logic        instr_valid,
  output logic        fetch_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] wait_cycles,
  output logic [15:0] stall_cycles
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  buf_q, buf_d;
  logic         req_c;
  logic [15:0]  tgt_c;

  // Redirect targets are always halfword aligned.
  assign tgt_c = br_target & ~16'h0001;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      pc_q    <= PC_RESET;
      buf_q   <= NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    req_c   = 1'b0;
    case (state_q)
      ST_REQ: begin
        // A redirect here suppresses the request so no response for the
        // old PC is ever in flight.
        if (br_taken) begin
          pc_d    = tgt_c;
          state_d = ST_REQ;
        end else begin
          req_c   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (br_taken) begin
          pc_d    = tgt_c;
          // Response arriving in the same cycle has already retired.
          state_d = imem.imem_valid ? ST_REQ : ST_DROP;
        end else if (imem.imem_valid) begin
          buf_d   = imem.imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          pc_d    = tgt_c;
          state_d = ST_REQ;
        end else if (!stall) begin
          if (buf_q[15:12] == HLT_OPCODE) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_REQ;
          end
        end
      end
      ST_DROP: begin
        if (br_taken) begin
          pc_d = tgt_c;
        end
        // The discarded response retires the outstanding read, even when a
        // further redirect lands in the same cycle.
        if (imem.imem_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (br_taken) begin
          pc_d    = tgt_c;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Reset parks the FSM in REQ; the request is held off until rst releases.
  assign imem.imem_req  = req_c & rst;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ST_HOLD);
  assign IF_Instr       = instr_valid ? buf_q : NOP_WORD;
  assign PC_out         = pc_q + PC_INC;
  assign fetch_halted   = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wait_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (state_q == ST_WAIT || state_q == ST_DROP) begin
        wait_cnt_q <= sat_inc16(wait_cnt_q);
      end
      if (state_q == ST_HOLD && stall) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

  assign wait_cycles  = wait_cnt_q;
  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A behavioural memory answers each request after a chosen latency; a stream
// model (expected next PC, expected word per address) judges the DUT.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, br_taken;
  logic [15:0] br_target, IF_Instr, PC_out;
  logic        instr_valid, fetch_halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] wait_cycles, stall_cycles;
`endif

  fetch_unit_if mif();

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem(mif), .IF_Instr(IF_Instr), .PC_out(PC_out), .instr_valid(instr_valid),
    .fetch_halted(fetch_halted)
`ifdef FETCH_PERF_CNT_EN
    , .wait_cycles(wait_cycles), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        drv_rst, drv_stall, drv_br;
  logic [15:0] drv_tgt;
  int          mem_cnt, mem_lat;
  bit          rand_lat;
  logic [15:0] mem_addr;
  logic [11:0] salt;
  bit          ovr_en;
  logic [15:0] ovr_addr, ovr_word;
  logic        s_req, s_vld, s_halt;
  logic [15:0] s_addr, s_instr, s_pc_out;

  // Memory contents: injective over even addresses, opcode nibble 1..8 (never HLT).
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] hi;
    if (ovr_en && a == ovr_addr) return ovr_word;
    hi = {1'b0, a[15:13]} + 4'd1;
    return {hi, a[12:1] ^ salt};
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample outputs 1ns later.
  task automatic step();
    @(negedge clk);
    rst = drv_rst; stall = drv_stall; br_taken = drv_br; br_target = drv_tgt;
    if (mem_cnt == 1) begin
      mif.imem_valid = 1'b1; mif.imem_rdata = mem_word(mem_addr); mem_cnt = 0;
    end else begin
      mif.imem_valid = 1'b0; mif.imem_rdata = 16'($urandom);
      if (mem_cnt > 1) mem_cnt--;
    end
    #1;
    s_req = mif.imem_req; s_addr = mif.imem_addr; s_vld = instr_valid;
    s_instr = IF_Instr; s_pc_out = PC_out; s_halt = fetch_halted;
    if (s_req === 1'b1 && rst === 1'b1) begin
      mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      mem_addr = s_addr;
    end
  endtask

  task automatic do_reset();
    drv_rst = 1'b0; drv_stall = 1'b0; drv_br = 1'b0; drv_tgt = 16'h0;
    ovr_en = 1'b0; rand_lat = 1'b0; mem_lat = 1; salt = 12'($urandom);
    step(); step();
    mem_cnt = 0; drv_rst = 1'b1;
  endtask

  task automatic test_reset();
    drv_rst = 1'b0; drv_stall = 1'b0; drv_br = 1'b0; drv_tgt = 16'h0; mem_lat = 1;
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", s_req); end
    checks++; if (s_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", s_vld); end
    checks++; if (s_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h want 0000", s_instr); end
    checks++; if (s_pc_out !== 16'h0002) begin errors++; $display("FAIL rst_pc_out got %h want 0002", s_pc_out); end
    checks++; if (s_halt !== 1'b0) begin errors++; $display("FAIL rst_halt got %b want 0", s_halt); end
    drv_rst = 1'b1;
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
      errors++; $display("FAIL rst_first_req got req=%b addr=%h want req=1 addr=0000", s_req, s_addr); end
  endtask

  task automatic test_sequential();
    int          rc[$];
    logic [15:0] ra[$], pcs[$];
    do_reset(); mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req) begin rc.push_back(i); ra.push_back(s_addr); end
      if (s_vld) pcs.push_back(s_pc_out);
    end
    checks++;
    if (rc.size() < 3 || pcs.size() < 2) begin
      errors++; $display("FAIL seq_count got reqs=%0d vlds=%0d want >=3 >=2", rc.size(), pcs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (rc[k] != 3 * k || ra[k] !== 16'(2 * k)) begin
          errors++; $display("FAIL seq_req%0d got cyc=%0d addr=%h want cyc=%0d addr=%h", k, rc[k], ra[k], 3 * k, 16'(2 * k)); end
      end
      checks++; if (pcs[0] !== 16'h0002 || pcs[1] !== 16'h0004) begin
        errors++; $display("FAIL seq_pc_out got %h %h want 0002 0004", pcs[0], pcs[1]); end
    end
  endtask

  task automatic test_stall();
    do_reset(); mem_lat = 2;
    ovr_en = 1'b1; ovr_addr = 16'h0300; ovr_word = 16'h1234;
    drv_br = 1'b1; drv_tgt = 16'h0300; step(); drv_br = 1'b0;
    drv_stall = 1'b1;
    for (int i = 0; i < 20 && s_vld !== 1'b1; i++) step();
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL stall_timeout got vld=%b want 1", s_vld); end
    checks++; if (s_instr !== 16'h1234 || s_pc_out !== 16'h0302) begin
      errors++; $display("FAIL stall_first got instr=%h pc_out=%h want 1234 0302", s_instr, s_pc_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (s_vld !== 1'b1 || s_instr !== 16'h1234 || s_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got vld=%b instr=%h req=%b want 1 1234 0", i, s_vld, s_instr, s_req); end
    end
    drv_stall = 1'b0; step();
    checks++; if (s_vld !== 1'b1 || s_instr !== 16'h1234) begin
      errors++; $display("FAIL stall_consume got vld=%b instr=%h want 1 1234", s_vld, s_instr); end
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0302 || s_vld !== 1'b0) begin
      errors++; $display("FAIL stall_next got req=%b addr=%h vld=%b want 1 0302 0", s_req, s_addr, s_vld); end
  endtask

  task automatic test_branch_wait();
    bit seen_req, seen_vld;
    do_reset(); mem_lat = 3;
    step();
    drv_br = 1'b1; drv_tgt = 16'h0100; step(); drv_br = 1'b0;
    seen_req = 0; seen_vld = 0;
    for (int i = 0; i < 20 && !seen_vld; i++) begin
      step();
      if (s_req && !seen_req) begin
        seen_req = 1;
        checks++; if (s_addr !== 16'h0100) begin errors++; $display("FAIL brw_addr got %h want 0100", s_addr); end
      end
      if (s_vld) begin
        seen_vld = 1;
        checks++; if (s_instr !== mem_word(16'h0100)) begin
          errors++; $display("FAIL brw_word got %h want %h", s_instr, mem_word(16'h0100)); end
      end
    end
    checks++; if (!seen_req || !seen_vld) begin
      errors++; $display("FAIL brw_timeout got req=%0d vld=%0d want 1 1", seen_req, seen_vld); end
    // Redirect coincident with the response: refetch starts immediately.
    do_reset(); mem_lat = 1;
    step();
    drv_br = 1'b1; drv_tgt = 16'h0080; step(); drv_br = 1'b0;
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0080 || s_vld !== 1'b0) begin
      errors++; $display("FAIL brv_next got req=%b addr=%h vld=%b want 1 0080 0", s_req, s_addr, s_vld); end
  endtask

  task automatic test_halt();
    do_reset(); mem_lat = 1;
    ovr_en = 1'b1; ovr_addr = 16'h0200; ovr_word = 16'hF000;
    drv_br = 1'b1; drv_tgt = 16'h0200; step(); drv_br = 1'b0;
    for (int i = 0; i < 20 && s_vld !== 1'b1; i++) step();
    checks++; if (s_vld !== 1'b1 || s_instr !== 16'hF000) begin
      errors++; $display("FAIL hlt_fetch got vld=%b instr=%h want 1 f000", s_vld, s_instr); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (s_halt !== 1'b1 || s_req !== 1'b0 || s_vld !== 1'b0 || s_instr !== 16'h0000) begin
        errors++; $display("FAIL hlt_idle%0d got halt=%b req=%b vld=%b instr=%h want 1 0 0 0000", i, s_halt, s_req, s_vld, s_instr); end
    end
    drv_br = 1'b1; drv_tgt = 16'h0041; step(); drv_br = 1'b0;
    step();
    checks++; if (s_halt !== 1'b0 || s_req !== 1'b1 || s_addr !== 16'h0040) begin
      errors++; $display("FAIL hlt_resume got halt=%b req=%b addr=%h want 0 1 0040", s_halt, s_req, s_addr); end
  endtask

  task automatic test_wrap();
    do_reset(); mem_lat = 1;
    drv_br = 1'b1; drv_tgt = 16'hFFFE; step(); drv_br = 1'b0;
    for (int i = 0; i < 20 && s_vld !== 1'b1; i++) step();
    checks++; if (s_vld !== 1'b1 || s_instr !== mem_word(16'hFFFE) || s_pc_out !== 16'h0000) begin
      errors++; $display("FAIL wrap_present got vld=%b instr=%h pc_out=%h want 1 %h 0000", s_vld, s_instr, s_pc_out, mem_word(16'hFFFE)); end
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_next got req=%b addr=%h want 1 0000", s_req, s_addr); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); mem_lat = 3;
    step(); step();
    drv_rst = 1'b0; step();
    checks++; if (s_req !== 1'b0 || s_vld !== 1'b0) begin
      errors++; $display("FAIL rmw_in_reset got req=%b vld=%b want 0 0", s_req, s_vld); end
    // Stale response (marked BAD0) lands in the cycle after release.
    drv_rst = 1'b1; ovr_en = 1'b1; ovr_addr = 16'h0000; ovr_word = 16'hBAD0;
    step();
    ovr_en = 1'b0;
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
      errors++; $display("FAIL rmw_first_req got req=%b addr=%h want 1 0000", s_req, s_addr); end
    for (int i = 0; i < 20 && s_vld !== 1'b1; i++) step();
    checks++; if (s_vld !== 1'b1 || s_instr !== mem_word(16'h0000)) begin
      errors++; $display("FAIL rmw_word got vld=%b instr=%h want 1 %h", s_vld, s_instr, mem_word(16'h0000)); end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    int          consumed;
    do_reset(); rand_lat = 1'b1;
    exp_pc = 16'h0000; consumed = 0;
    for (int i = 0; i < 800; i++) begin
      drv_stall = ($urandom_range(0, 99) < 30);
      drv_br    = ($urandom_range(0, 99) < 4);
      drv_tgt   = 16'($urandom);
      step();
      if (s_req === 1'b1) begin
        checks++; if (s_addr !== exp_pc) begin
          errors++; $display("FAIL rnd_addr cyc=%0d got %h want %h", i, s_addr, exp_pc); end
      end
      if (s_vld === 1'b1) begin
        checks++; if (s_instr !== mem_word(exp_pc) || s_pc_out !== 16'(exp_pc + 16'd2)) begin
          errors++; $display("FAIL rnd_present cyc=%0d got instr=%h pc_out=%h want %h %h", i, s_instr, s_pc_out, mem_word(exp_pc), 16'(exp_pc + 16'd2)); end
        if (!drv_stall && !drv_br) begin exp_pc = exp_pc + 16'd2; consumed++; end
      end else begin
        checks++; if (s_instr !== 16'h0000) begin
          errors++; $display("FAIL rnd_bubble cyc=%0d got %h want 0000", i, s_instr); end
      end
      checks++; if (s_halt !== 1'b0) begin errors++; $display("FAIL rnd_halt cyc=%0d got %b want 0", i, s_halt); end
      if (drv_br) exp_pc = drv_tgt & 16'hFFFE;
    end
    drv_stall = 1'b0; drv_br = 1'b0;
    checks++; if (consumed < 20) begin errors++; $display("FAIL rnd_progress got %0d want >=20", consumed); end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    mif.imem_valid = 1'b0; mif.imem_rdata = 16'h0;
    mem_cnt = 0; mem_lat = 1; rand_lat = 1'b0; ovr_en = 1'b0; salt = 12'h5A3;
    ovr_addr = 16'h0; ovr_word = 16'h0; mem_addr = 16'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_halt();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
